// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit_pkg
//  Brief    : Shared encodings for the MEM-stage load/store engine
//             (load/store type codes, FSM state codes, word geometry).
//  Revision : 1.0  initial release
// ============================================================================
package mem_access_unit_pkg;

    // Load type encodings; 6 and 7 decode as "no load"
    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LW   = 3'd3;
    localparam logic [2:0] LD_LBU  = 3'd4;
    localparam logic [2:0] LD_LHU  = 3'd5;

    // Store type encodings
    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    // Transaction FSM state encoding
    localparam int         STATE_W = 2;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Bytes per data word
    localparam int WORD_BYTES = 4;

    // True for the five real load encodings
    function automatic logic is_load_type(input logic [2:0] t);
        return (t >= LD_LB) && (t <= LD_LHU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_load_align
//  Brief    : Combinational load-data aligner. Picks the addressed byte or
//             halfword from a raw word and sign/zero-extends it.
//  Revision : 1.0  initial release
// ============================================================================
module mem_load_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            byte_off,
    input  logic [2:0]            ld_type,
    output logic [DATA_WIDTH-1:0] aligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane selection by low address bits
    always_comb begin
        w_byte = rdata[7:0];
        case (byte_off)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    // Halfword lane selection; aligned halves only, so bit 1 decides
    always_comb begin
        w_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension according to the load type; LW and "none" pass through
    always_comb begin
        aligned = rdata;
        case (ld_type)
            LD_LB:   aligned = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            LD_LBU:  aligned = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            LD_LH:   aligned = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            LD_LHU:  aligned = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: aligned = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Brief    : MEM-stage load/store engine. Accepts one op from EX, runs a
//             single-outstanding req/ack access to the D-cache, builds byte
//             enables, aligns load data and stalls the pipe meanwhile.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_ldst_flag,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_store_data,
    input  logic [2:0]            ex_ld_type,
    input  logic [1:0]            ex_st_type,
    input  logic                  ex_flush,
    output logic                  dcache_req,
    output logic                  dcache_we,
    output logic [ADDR_WIDTH-1:0] dcache_addr,
    output logic [DATA_WIDTH-1:0] dcache_wdata,
    output logic [WORD_BYTES-1:0] dcache_be,
    input  logic                  dcache_ack,
    input  logic [DATA_WIDTH-1:0] dcache_rdata,
    output logic                  mem_stall,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rdata_valid,
    output logic                  misalign_exc,
    output logic [ADDR_WIDTH-1:0] misalign_addr
);

    logic [STATE_W-1:0]    r_state;
    logic [STATE_W-1:0]    w_state_next;

    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_start;
    logic [WORD_BYTES-1:0] w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_align_data;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_ld_type;
    logic                  r_is_load;
    logic                  r_we;
    logic [WORD_BYTES-1:0] r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_misalign_exc;
    logic [ADDR_WIDTH-1:0] r_misalign_addr;

    // A load wins when both types are set, so the store is dropped
    assign w_is_load  = is_load_type(ex_ld_type);
    assign w_is_store = (ex_st_type != ST_NONE) && !w_is_load;
    assign w_accept   = (r_state == S_IDLE) && ex_valid && ex_ldst_flag &&
                        !ex_flush && (w_is_load || w_is_store);
    assign w_start    = w_accept && !w_misalign;

    // Natural-alignment check on the incoming effective address
    always_comb begin
        w_misalign = 1'b0;
        if (w_is_load) begin
            case (ex_ld_type)
                LD_LH, LD_LHU: w_misalign = ex_addr[0];
                LD_LW:         w_misalign = |ex_addr[1:0];
                default:       w_misalign = 1'b0;
            endcase
        end else begin
            case (ex_st_type)
                ST_SH:   w_misalign = ex_addr[0];
                ST_SW:   w_misalign = |ex_addr[1:0];
                default: w_misalign = 1'b0;
            endcase
        end
    end

    // Store lane steering: replicate data across lanes, enable the addressed ones
    always_comb begin
        w_be    = {WORD_BYTES{1'b1}};
        w_wdata = ex_store_data;
        if (w_is_store) begin
            case (ex_st_type)
                ST_SB: begin
                    w_be    = 4'b0001 << ex_addr[1:0];
                    w_wdata = {(DATA_WIDTH/8){ex_store_data[7:0]}};
                end
                ST_SH: begin
                    w_be    = 4'b0011 << ex_addr[1:0];
                    w_wdata = {(DATA_WIDTH/16){ex_store_data[15:0]}};
                end
                default: begin
                    w_be    = {WORD_BYTES{1'b1}};
                    w_wdata = ex_store_data;
                end
            endcase
        end
    end

    mem_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .rdata    (dcache_rdata),
        .byte_off (r_addr[1:0]),
        .ld_type  (r_ld_type),
        .aligned  (w_align_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; flush is only looked at through w_accept in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start)    w_state_next = S_REQ;
            S_REQ:   if (dcache_ack) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs; the accept cycle stalls combinationally
    always_comb begin
        dcache_req      = (r_state == S_REQ);
        mem_stall       = w_start || (r_state == S_REQ);
        mem_rdata_valid = (r_state == S_DONE) && r_is_load;
    end

    // Captured request fields, load result and misalignment trap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr          <= '0;
            r_ld_type       <= LD_NONE;
            r_is_load       <= 1'b0;
            r_we            <= 1'b0;
            r_be            <= '0;
            r_wdata         <= '0;
            r_rdata         <= '0;
            r_misalign_exc  <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign_exc <= w_accept && w_misalign;
            if (w_accept && w_misalign) begin
                r_misalign_addr <= ex_addr;
            end
            if (w_start) begin
                r_addr    <= ex_addr;
                r_ld_type <= ex_ld_type;
                r_is_load <= w_is_load;
                r_we      <= w_is_store;
                r_be      <= w_be;
                r_wdata   <= w_wdata;
            end
            if ((r_state == S_REQ) && dcache_ack && r_is_load) begin
                r_rdata <= w_align_data;
            end
        end
    end

    assign dcache_we     = r_we;
    assign dcache_addr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign dcache_wdata  = r_wdata;
    assign dcache_be     = r_be;
    assign mem_rdata     = r_rdata;
    assign misalign_exc  = r_misalign_exc;
    assign misalign_addr = r_misalign_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Brief    : Self-checking bench for mem_access_unit: directed cases plus
//             randomized ops against a behavioural load/store model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ldst_flag;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_ld_type;
    logic [1:0]  ex_st_type;
    logic        ex_flush;
    logic        dcache_req;
    logic        dcache_we;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_wdata;
    logic [3:0]  dcache_be;
    logic        dcache_ack;
    logic [31:0] dcache_rdata;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic        misalign_exc;
    logic [31:0] misalign_addr;

    int total;
    int bad;

    mem_access_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid        (ex_valid),
        .ex_ldst_flag    (ex_ldst_flag),
        .ex_addr         (ex_addr),
        .ex_store_data   (ex_store_data),
        .ex_ld_type      (ex_ld_type),
        .ex_st_type      (ex_st_type),
        .ex_flush        (ex_flush),
        .dcache_req      (dcache_req),
        .dcache_we       (dcache_we),
        .dcache_addr     (dcache_addr),
        .dcache_wdata    (dcache_wdata),
        .dcache_be       (dcache_be),
        .dcache_ack      (dcache_ack),
        .dcache_rdata    (dcache_rdata),
        .mem_stall       (mem_stall),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .misalign_exc    (misalign_exc),
        .misalign_addr   (misalign_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_is_load(input logic [2:0] ld);
        return (ld >= 3'd1) && (ld <= 3'd5);
    endfunction

    function automatic int m_size(input logic [2:0] ld, input logic [1:0] st);
        if (m_is_load(ld)) begin
            if (ld == 3'd1 || ld == 3'd4) return 1;
            if (ld == 3'd2 || ld == 3'd5) return 2;
            return 4;
        end
        if (st == 2'd1) return 1;
        if (st == 2'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [2:0] ld);
        int off;
        int v;
        off = int'(a % 4);
        case (ld)
            3'd1: begin v = int'((rd >> (8 * off)) & 32'hFF);   return 32'((v ^ 128) - 128);     end
            3'd4: begin v = int'((rd >> (8 * off)) & 32'hFF);   return 32'(v);                   end
            3'd2: begin v = int'((rd >> (8 * off)) & 32'hFFFF); return 32'((v ^ 32768) - 32768); end
            3'd5: begin v = int'((rd >> (8 * off)) & 32'hFFFF); return 32'(v);                   end
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] m_be(input int sz, input bit is_st, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (!is_st || sz == 4) return 32'd15;
        if (sz == 1) return 32'(1 << off);
        return 32'(3 << off);
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
        if (sz == 1) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        ex_valid      = 1'b0;
        ex_ldst_flag  = 1'b0;
        ex_flush      = 1'b0;
        ex_ld_type    = 3'd0;
        ex_st_type    = 2'd0;
        ex_addr       = $urandom;
        ex_store_data = $urandom;
    endtask

    task automatic drive_op(input logic [2:0] ld, input logic [1:0] st,
                            input logic [31:0] a, input logic [31:0] d, input bit fl);
        ex_valid      = 1'b1;
        ex_ldst_flag  = 1'b1;
        ex_ld_type    = ld;
        ex_st_type    = st;
        ex_addr       = a;
        ex_store_data = d;
        ex_flush      = fl;
    endtask

    // Aligned op: accept, REQ for waits+1 cycles, then DONE; ends inside DONE
    task automatic run_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd, input int waits,
                          input bit flush_mid);
        bit ldop;
        bit stop;
        int sz;
        ldop = m_is_load(ld);
        stop = (st != 2'd0) && !ldop;
        sz   = m_size(ld, st);
        @(posedge clk); #1;
        drive_op(ld, st, a, d, 1'b0);
        #1;
        chk("acc_stall", 32'(mem_stall), 32'd1);
        chk("acc_req", 32'(dcache_req), 32'd0);
        for (int k = 0; k <= waits; k++) begin
            @(posedge clk); #1;
            ex_flush     = flush_mid && (k == 1);
            dcache_ack   = (k == waits);
            dcache_rdata = (k == waits) ? rd : $urandom;
            #1;
            chk("req_req", 32'(dcache_req), 32'd1);
            chk("req_stall", 32'(mem_stall), 32'd1);
            chk("req_addr", dcache_addr, a & 32'hFFFF_FFFC);
            chk("req_we", 32'(dcache_we), 32'(stop));
            chk("req_be", 32'(dcache_be), m_be(sz, stop, a));
            if (stop) chk("req_wdata", dcache_wdata, m_wdata(sz, d));
        end
        @(posedge clk); #1;
        dcache_ack   = 1'b0;
        ex_flush     = 1'b0;
        dcache_rdata = $urandom;
        #1;
        chk("done_req", 32'(dcache_req), 32'd0);
        chk("done_stall", 32'(mem_stall), 32'd0);
        chk("done_valid", 32'(mem_rdata_valid), 32'(ldop));
        if (ldop) chk("done_rdata", mem_rdata, m_load(rd, a, ld));
    endtask

    // Misaligned op: no request, one-cycle trap pulse next cycle
    task automatic run_misalign(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a);
        @(posedge clk); #1;
        drive_op(ld, st, a, $urandom, 1'b0);
        #1;
        chk("mis_stall", 32'(mem_stall), 32'd0);
        chk("mis_req0", 32'(dcache_req), 32'd0);
        @(posedge clk); #1;
        drive_idle();
        #1;
        chk("mis_exc", 32'(misalign_exc), 32'd1);
        chk("mis_addr", misalign_addr, a);
        chk("mis_req1", 32'(dcache_req), 32'd0);
        @(posedge clk); #1;
        chk("mis_exc_clr", 32'(misalign_exc), 32'd0);
    endtask

    // Flushed op in IDLE: nothing is taken
    task automatic run_flushed(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a);
        @(posedge clk); #1;
        drive_op(ld, st, a, $urandom, 1'b1);
        #1;
        chk("fl_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        drive_idle();
        #1;
        chk("fl_req", 32'(dcache_req), 32'd0);
        chk("fl_exc", 32'(misalign_exc), 32'd0);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        drive_idle();
        #1;
        chk("idle_stall", 32'(mem_stall), 32'd0);
        chk("idle_valid", 32'(mem_rdata_valid), 32'd0);
    endtask

    initial begin
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [31:0] a;
        int          sz;
        int          kind;
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        dcache_ack   = 1'b0;
        dcache_rdata = 32'd0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(dcache_req), 32'd0);
        chk("rst_we", 32'(dcache_we), 32'd0);
        chk("rst_addr", dcache_addr, 32'd0);
        chk("rst_wdata", dcache_wdata, 32'd0);
        chk("rst_be", 32'(dcache_be), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_valid", 32'(mem_rdata_valid), 32'd0);
        chk("rst_exc", 32'(misalign_exc), 32'd0);
        chk("rst_maddr", misalign_addr, 32'd0);
        rst = 1'b0;

        // Directed loads
        run_op(3'd3, 2'd0, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        chk("lw_const", mem_rdata, 32'hDEADBEEF);
        idle_cycle();
        run_op(3'd1, 2'd0, 32'h1003, 32'h0, 32'h80FFFFFF, 0, 1'b0);
        chk("lb_const", mem_rdata, 32'hFFFFFF80);
        run_op(3'd4, 2'd0, 32'h1003, 32'h0, 32'h80FFFFFF, 1, 1'b0);
        chk("lbu_const", mem_rdata, 32'h00000080);
        run_op(3'd2, 2'd0, 32'h1002, 32'h0, 32'h80011234, 0, 1'b0);
        chk("lh_const", mem_rdata, 32'hFFFF8001);
        run_op(3'd5, 2'd0, 32'h1002, 32'h0, 32'h80011234, 0, 1'b0);
        chk("lhu_const", mem_rdata, 32'h00008001);

        // Directed stores
        run_op(3'd0, 2'd1, 32'h2001, 32'h000000AB, 32'h0, 0, 1'b0);
        run_op(3'd0, 2'd2, 32'h2002, 32'h0000BEEF, 32'h0, 0, 1'b0);
        run_op(3'd0, 2'd3, 32'h2000, 32'h12345678, 32'h0, 0, 1'b0);
        idle_cycle();

        // Misaligned word load
        run_misalign(3'd3, 2'd0, 32'h1002);

        // Long wait with flush pulsed mid-REQ; load+store both set -> load wins
        run_op(3'd3, 2'd3, 32'h3000, 32'hCAFEF00D, 32'h5A5A1234, 5, 1'b1);
        idle_cycle();

        // Reset during REQ, later ack ignored
        @(posedge clk); #1;
        drive_op(3'd3, 2'd0, 32'h4000, 32'h0, 1'b0);
        #1;
        chk("rr_acc", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        drive_idle();
        #1;
        chk("rr_req", 32'(dcache_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rr_req_drop", 32'(dcache_req), 32'd0);
        chk("rr_stall", 32'(mem_stall), 32'd0);
        dcache_ack   = 1'b1;
        dcache_rdata = 32'h11112222;
        @(posedge clk); #1;
        dcache_ack = 1'b0;
        #1;
        chk("rr_valid", 32'(mem_rdata_valid), 32'd0);
        chk("rr_req2", 32'(dcache_req), 32'd0);
        chk("rr_rdata", mem_rdata, 32'd0);

        // Back-to-back SW then LW
        run_op(3'd0, 2'd3, 32'h5000, 32'hA5A5A5A5, 32'h0, 0, 1'b0);
        run_op(3'd3, 2'd0, 32'h5004, 32'h0, 32'h0BADCAFE, 0, 1'b0);
        idle_cycle();

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                run_flushed(3'd3, 2'd0, $urandom & 32'hFFFF_FFFC);
            end else if (kind == 1) begin
                if ($urandom_range(0, 1) == 1) begin
                    ld = ($urandom_range(0, 1) == 1) ? 3'd2 : 3'd5;
                    st = 2'd0;
                end else begin
                    ld = 3'd0;
                    st = 2'd2;
                end
                a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1) * 2 + 1);
                run_misalign(ld, st, a);
            end else begin
                ld = 3'($urandom_range(0, 7));
                st = 2'($urandom_range(0, 3));
                if (!m_is_load(ld) && st == 2'd0) st = 2'd3;
                sz = m_size(ld, st);
                a  = $urandom & ~32'(sz - 1);
                run_op(ld, st, a, $urandom, $urandom, int'($urandom_range(0, 3)), 1'b0);
                if ($urandom_range(0, 1) == 1) idle_cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
